// File: rtl/mux2_to_1_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mux2_to_1_arb_if
// Description : Handshake bundle for the two-lane to one-lane stream merger.
//               Carries both upstream lanes (data/valid/ready) and the
//               tagged downstream stream (data/valid/ready/sel).
// Modports    : master - arbiter side (drives readies and the output stream)
//               slave  - environment side (drives lane data/valid and
//                        downstream ready)
// Signals     : in_0/in_0_valid/in_0_ready   lane 0 stream
//               in_1/in_1_valid/in_1_ready   lane 1 stream
//               mux_out/mux_out_valid/mux_out_ready/mux_out_sel  merged stream
// Revision    : 1.0 - initial release
// ============================================================================
interface mux2_to_1_arb_if #(
    parameter int N = 10
);
    logic [N-1:0] in_0;
    logic         in_0_valid;
    logic         in_0_ready;
    logic [N-1:0] in_1;
    logic         in_1_valid;
    logic         in_1_ready;
    logic [N-1:0] mux_out;
    logic         mux_out_valid;
    logic         mux_out_ready;
    logic         mux_out_sel;

    modport master (
        input  in_0, in_0_valid, in_1, in_1_valid, mux_out_ready,
        output in_0_ready, in_1_ready, mux_out, mux_out_valid, mux_out_sel
    );

    modport slave (
        output in_0, in_0_valid, in_1, in_1_valid, mux_out_ready,
        input  in_0_ready, in_1_ready, mux_out, mux_out_valid, mux_out_sel
    );
endinterface
`default_nettype wire

// File: rtl/mux2_to_1_arb.sv
`default_nettype none
// ============================================================================
// Module      : mux2_to_1_arb
// Description : Merges two valid/ready lanes into one registered output
//               stream with round-robin arbitration; each output beat is
//               tagged with its source lane (mux_out_sel).
// Ports       : clk  - clock, all state updates on rising edge
//               rst  - synchronous active-high reset
//               bus  - mux2_to_1_arb_if.master (lane inputs, merged output)
// Parameters  : N    - data width (must match the connected interface)
// Macros      : MUX2_FIXED_PRIO_EN - when defined, lane 0 always wins ties
//               and the round-robin priority register is removed.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_to_1_arb #(
    parameter int N = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mux2_to_1_arb_if.master  bus
);

    logic [N-1:0] data_q, data_d;
    logic         sel_q,  sel_d;
    logic         valid_q, valid_d;

    logic         load;
    logic         grant_0;
    logic         grant_1;
    logic         acc_0;
    logic         acc_1;

    // The output register may take a new beat when empty or being drained
    // this cycle; this makes mux_out_ready -> in_*_ready combinational.
    assign load = !valid_q || bus.mux_out_ready;

`ifdef MUX2_FIXED_PRIO_EN
    // Lane 0 has absolute priority; lane 1 only when lane 0 is idle.
    assign grant_0 = bus.in_0_valid;
    assign grant_1 = bus.in_1_valid && !bus.in_0_valid;
`else
    logic prio_q, prio_d;

    // On contention the lane matching prio wins; a lone valid always wins.
    assign grant_0 = bus.in_0_valid && (!bus.in_1_valid || !prio_q);
    assign grant_1 = bus.in_1_valid && (!bus.in_0_valid ||  prio_q);
`endif

    // Grants already imply valid, so ready doubles as the accept strobe.
    assign bus.in_0_ready = load && grant_0;
    assign bus.in_1_ready = load && grant_1;
    assign acc_0          = bus.in_0_ready;
    assign acc_1          = bus.in_1_ready;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (load) begin
            if (acc_0) begin
                data_d  = bus.in_0;
                sel_d   = 1'b0;
                valid_d = 1'b1;
            end else if (acc_1) begin
                data_d  = bus.in_1;
                sel_d   = 1'b1;
                valid_d = 1'b1;
            end else begin
                // Drain: data and sel are kept, only valid drops.
                valid_d = 1'b0;
            end
        end
    end

`ifndef MUX2_FIXED_PRIO_EN
    // After serving lane k the other lane gets priority.
    always_comb begin
        prio_d = prio_q;
        if (acc_0) begin
            prio_d = 1'b1;
        end else if (acc_1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.mux_out       = data_q;
    assign bus.mux_out_sel   = sel_q;
    assign bus.mux_out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux2_to_1_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux2_to_1_arb
// Description : Directed, table-driven self-checking bench for mux2_to_1_arb.
//               Each record gives the inputs for one cycle, the readies
//               expected before the edge and the output register expected
//               after it. Honours MUX2_FIXED_PRIO_EN for tie-break results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_to_1_arb;

    localparam int N = 10;

    typedef struct {
        bit         rst;
        bit         v0;
        bit [N-1:0] d0;
        bit         v1;
        bit [N-1:0] d1;
        bit         rdy;
        bit         er0;
        bit         er1;
        bit         ev;
        bit [N-1:0] ed;
        bit         es;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    mux2_to_1_arb_if #(.N(N)) bus ();

    mux2_to_1_arb #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v0, input bit [N-1:0] d0,
                         input bit v1, input bit [N-1:0] d1, input bit rdy);
        rst               = r;
        bus.in_0_valid    = v0;
        bus.in_0          = d0;
        bus.in_1_valid    = v1;
        bus.in_1          = d1;
        bus.mux_out_ready = rdy;
    endtask

    // Drive one cycle, check readies before the edge, outputs after it.
    task automatic apply(input vec_t v, input int idx);
        drive(v.rst, v.v0, v.d0, v.v1, v.d1, v.rdy);
        #1;
        check("in_0_ready", idx, 32'(bus.in_0_ready), 32'(v.er0));
        check("in_1_ready", idx, 32'(bus.in_1_ready), 32'(v.er1));
        @(posedge clk);
        #1;
        check("mux_out_valid", idx, 32'(bus.mux_out_valid), 32'(v.ev));
        check("mux_out",       idx, 32'(bus.mux_out),       32'(v.ed));
        check("mux_out_sel",   idx, 32'(bus.mux_out_sel),   32'(v.es));
    endtask

    function automatic vec_t mk(bit r, bit v0, int d0, bit v1, int d1, bit rdy,
                                bit er0, bit er1, bit ev, int ed, bit es);
        vec_t v;
        v.rst = r;  v.v0 = v0;   v.d0 = N'(d0); v.v1 = v1; v.d1 = N'(d1);
        v.rdy = rdy; v.er0 = er0; v.er1 = er1;  v.ev = ev;  v.ed = N'(ed);
        v.es  = es;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        //               rst v0 d0     v1 d1     rdy  er0 er1 ev ed     es
        // Reset with both lanes valid, then first accept from lane 0
        vecs.push_back(mk(1, 1, 5,     1, 6,     1,   1,  0,  0, 0,     0));
        vecs.push_back(mk(0, 1, 5,     1, 6,     1,   1,  0,  1, 5,     0));
        // Single lane back-to-back
        vecs.push_back(mk(0, 1, 123,   0, 0,     1,   1,  0,  1, 123,   0));
        vecs.push_back(mk(0, 1, 124,   0, 0,     1,   1,  0,  1, 124,   0));
        vecs.push_back(mk(0, 1, 125,   0, 0,     1,   1,  0,  1, 125,   0));
        // Drain: valid falls, data retained
        vecs.push_back(mk(0, 0, 0,     0, 0,     1,   0,  0,  0, 125,   0));
        vecs.push_back(mk(0, 0, 0,     0, 0,     0,   0,  0,  0, 125,   0));
        // Lane 1 beat, leaving priority with lane 0
        vecs.push_back(mk(0, 0, 0,     1, 200,   1,   0,  1,  1, 200,   1));
        // Both lanes continuously valid
`ifdef MUX2_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 'h0AA, 1, 'h155, 1, 1, 0, 1, 'h0AA, 0));
`else
        vecs.push_back(mk(0, 1, 'h0AA, 1, 'h155, 1,   1,  0,  1, 'h0AA, 0));
        vecs.push_back(mk(0, 1, 'h0AA, 1, 'h155, 1,   0,  1,  1, 'h155, 1));
        vecs.push_back(mk(0, 1, 'h0AA, 1, 'h155, 1,   1,  0,  1, 'h0AA, 0));
        vecs.push_back(mk(0, 1, 'h0AA, 1, 'h155, 1,   0,  1,  1, 'h155, 1));
`endif
        // Backpressure: 77 from lane 1, stall 5 cycles, release to lane 0
        vecs.push_back(mk(0, 0, 0,     1, 77,    1,   0,  1,  1, 77,    1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 88, 1, 99,   0,   0,  0,  1, 77,    1));
        vecs.push_back(mk(0, 1, 88,    1, 99,    1,   1,  0,  1, 88,    0));
        vecs.push_back(mk(0, 0, 0,     0, 0,     1,   0,  0,  0, 88,    0));
        // Reset while a beat is held and stalled: beat is discarded
        vecs.push_back(mk(0, 0, 0,     1, 300,   1,   0,  1,  1, 300,   1));
        vecs.push_back(mk(0, 0, 0,     0, 0,     0,   0,  0,  1, 300,   1));
        vecs.push_back(mk(1, 1, 9,     0, 0,     0,   0,  0,  0, 0,     0));
        vecs.push_back(mk(0, 0, 0,     0, 0,     0,   0,  0,  0, 0,     0));

        // Initialise out of reset before checking anything
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Hand sequence: after a lane 0 beat, contention goes to lane 1
        // (round-robin) or stays with lane 0 (fixed priority).
        drive(0, 1, 11, 0, 0, 1);
        #1;
        check("hs_in_0_ready", 100, 32'(bus.in_0_ready), 32'd1);
        @(posedge clk);
        #1;
        check("hs_mux_out", 100, 32'(bus.mux_out), 32'd11);

        drive(0, 1, 12, 1, 13, 1);
        #1;
`ifdef MUX2_FIXED_PRIO_EN
        check("hs_in_1_ready", 101, 32'(bus.in_1_ready), 32'd0);
        @(posedge clk);
        #1;
        check("hs_mux_out", 101, 32'(bus.mux_out), 32'd12);
        check("hs_mux_out_sel", 101, 32'(bus.mux_out_sel), 32'd0);
`else
        check("hs_in_1_ready", 101, 32'(bus.in_1_ready), 32'd1);
        @(posedge clk);
        #1;
        check("hs_mux_out", 101, 32'(bus.mux_out), 32'd13);
        check("hs_mux_out_sel", 101, 32'(bus.mux_out_sel), 32'd1);
`endif
        #1;
        check("hs_in_0_ready", 102, 32'(bus.in_0_ready), 32'd1);
        @(posedge clk);
        #1;
        check("hs_mux_out", 102, 32'(bus.mux_out), 32'd12);
        check("hs_mux_out_sel", 102, 32'(bus.mux_out_sel), 32'd0);
        check("hs_mux_out_valid", 102, 32'(bus.mux_out_valid), 32'd1);

        drive(0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
